// File: rtl/spi_frame_decoder_pkg.sv
// Shared definitions for the SPI byte-stream frame decoder: opcodes, FSM states,
// status-byte layout and default framebuffer geometry.
package spi_frame_decoder_pkg;

    localparam logic [7:0] OP_WR_PIX  = 8'h01;
    localparam logic [7:0] OP_SET_BRT = 8'h02;
    localparam logic [7:0] OP_RD_STAT = 8'h03;

    localparam int STAT_ERR_BIT = 7;
    localparam int STAT_CNT_LSB = 0;
    localparam int STAT_CNT_W   = 4;

    localparam int DEF_NUM_PIXELS = 2048;
    localparam int DEF_ADDR_W     = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_PIX_R,
        ST_PIX_G,
        ST_PIX_B,
        ST_BRT,
        ST_DRAIN
    } state_t;

    function automatic logic [7:0] status_byte(input logic e, input logic [STAT_CNT_W-1:0] cnt);
        logic [7:0] s;
        s = '0;
        s[STAT_ERR_BIT] = e;
        s[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
        return s;
    endfunction

endpackage

// File: rtl/spi_frame_decoder_if.sv
// Byte-stream, status-reply and framebuffer-port bundle between the SPI slave
// front end and the frame decoder.
interface spi_frame_decoder_if
    import spi_frame_decoder_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              cs_n;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_req;
    logic [7:0]        tx_data;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [23:0]       fb_wdata;
    logic [7:0]        brightness;
    logic              err;

    modport master (
        output cs_n, rx_valid, rx_data,
        input  tx_req, tx_data, fb_we, fb_addr, fb_wdata, brightness, err
    );

    modport slave (
        input  cs_n, rx_valid, rx_data,
        output tx_req, tx_data, fb_we, fb_addr, fb_wdata, brightness, err
    );
endinterface

// File: rtl/spi_frame_decoder.sv
// Decodes cs_n-framed MOSI bytes into pixel writes, brightness updates and
// status replies loaded into the MISO path on the next frame boundary.
module spi_frame_decoder
    import spi_frame_decoder_pkg::*;
#(
    parameter int NUM_PIXELS = DEF_NUM_PIXELS,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic                clk_sb,
    input  logic                reset_n,
    spi_frame_decoder_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    state_t            state;
    logic [7:0]        addr_hi;
    logic [7:0]        r_lat;
    logic [7:0]        g_lat;
    logic [ADDR_W-1:0] cur_addr;
    logic [3:0]        frame_cnt;
    logic              status_pend;
    logic              pix_written;

    logic              tx_req_q;
    logic [7:0]        tx_data_q;
    logic              fb_we_q;
    logic [ADDR_W-1:0] fb_addr_q;
    logic [23:0]       fb_wdata_q;
    logic [7:0]        brightness_q;
    logic              err_q;

    logic [15:0]       addr_word;
    logic              addr_ok;
    logic              byte_in;

    // A byte only counts while the frame is open; cs_n high drops a coincident byte.
    assign byte_in   = bus.rx_valid && !bus.cs_n;
    assign addr_word = {addr_hi, bus.rx_data};
    assign addr_ok   = ({16'd0, addr_word} < 32'(NUM_PIXELS));

    always_ff @(posedge clk_sb or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            frame_cnt    <= '0;
            status_pend  <= 1'b0;
            pix_written  <= 1'b0;
            tx_req_q     <= 1'b0;
            tx_data_q    <= '0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_wdata_q   <= '0;
            brightness_q <= 8'hFF;
            err_q        <= 1'b0;
        end else begin
            tx_req_q <= 1'b0;
            fb_we_q  <= 1'b0;
            if (bus.cs_n) begin
                state       <= ST_IDLE;
                pix_written <= 1'b0;
                if (pix_written)
                    frame_cnt <= frame_cnt + 4'd1;
                if (status_pend) begin
                    tx_req_q    <= 1'b1;
                    tx_data_q   <= status_byte(err_q, frame_cnt);
                    status_pend <= 1'b0;
                    err_q       <= 1'b0;
                end
            end else if (bus.rx_valid) begin
                unique case (state)
                    ST_IDLE: begin
                        case (bus.rx_data)
                            OP_WR_PIX:  state <= ST_ADDR_HI;
                            OP_SET_BRT: state <= ST_BRT;
                            OP_RD_STAT: begin
                                status_pend <= 1'b1;
                                state       <= ST_DRAIN;
                            end
                            default: begin
                                err_q <= 1'b1;
                                state <= ST_DRAIN;
                            end
                        endcase
                    end
                    ST_ADDR_HI: state <= ST_ADDR_LO;
                    ST_ADDR_LO: begin
                        if (addr_ok) begin
                            state <= ST_PIX_R;
                        end else begin
                            err_q <= 1'b1;
                            state <= ST_DRAIN;
                        end
                    end
                    ST_PIX_R: state <= ST_PIX_G;
                    ST_PIX_G: state <= ST_PIX_B;
                    ST_PIX_B: begin
                        fb_we_q     <= 1'b1;
                        fb_addr_q   <= cur_addr;
                        fb_wdata_q  <= {r_lat, g_lat, bus.rx_data};
                        pix_written <= 1'b1;
                        state       <= ST_PIX_R;
                    end
                    ST_BRT: begin
                        brightness_q <= bus.rx_data;
                        state        <= ST_DRAIN;
                    end
                    ST_DRAIN: state <= ST_DRAIN;
                    default:  state <= ST_DRAIN;
                endcase
            end
        end
    end

    // Byte latches and the running address need no reset: every frame reloads them before use.
    always_ff @(posedge clk_sb) begin
        if (byte_in) begin
            case (state)
                ST_ADDR_HI: addr_hi  <= bus.rx_data;
                ST_ADDR_LO: cur_addr <= addr_word[ADDR_W-1:0];
                ST_PIX_R:   r_lat    <= bus.rx_data;
                ST_PIX_G:   g_lat    <= bus.rx_data;
                ST_PIX_B:   cur_addr <= (cur_addr == LAST_ADDR) ? '0 : cur_addr + ADDR_W'(1);
                default: ;
            endcase
        end
    end

    assign bus.tx_req     = tx_req_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.fb_we      = fb_we_q;
    assign bus.fb_addr    = fb_addr_q;
    assign bus.fb_wdata   = fb_wdata_q;
    assign bus.brightness = brightness_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Directed bench for spi_frame_decoder: expected pixel writes are queued as bytes
// are driven and matched by a monitor when fb_we fires.
module tb_spi_frame_decoder;

    typedef struct {
        logic [10:0] addr;
        logic [23:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int tx_cnt = 0;
    logic [7:0] tx_last = 8'h00;
    wr_t exp_q[$];
    wr_t mon_e;

    spi_frame_decoder_if #(.ADDR_W(11)) bus ();

    spi_frame_decoder #(.NUM_PIXELS(2048), .ADDR_W(11)) dut (
        .clk_sb  (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.fb_we === 1'b1) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                chk("fb_we_unexpected", 32'(bus.fb_we), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("fb_addr", 32'(bus.fb_addr), 32'(mon_e.addr));
                chk("fb_wdata", 32'(bus.fb_wdata), 32'(mon_e.data));
            end
        end
        if (bus.tx_req === 1'b1) begin
            tx_cnt++;
            tx_last = bus.tx_data;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame_begin();
        @(negedge clk);
        bus.cs_n = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame_end();
        @(negedge clk);
        bus.cs_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic push_wr(input logic [10:0] a, input logic [23:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_req"}, 32'(bus.tx_req), 32'd0);
        chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
        chk({tag, "_fb_we"}, 32'(bus.fb_we), 32'd0);
        chk({tag, "_fb_addr"}, 32'(bus.fb_addr), 32'd0);
        chk({tag, "_fb_wdata"}, 32'(bus.fb_wdata), 32'd0);
        chk({tag, "_brightness"}, 32'(bus.brightness), 32'hFF);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
    endtask

    task automatic read_status(input string tag, input logic [7:0] exp);
        int t0;
        t0 = tx_cnt;
        frame_begin();
        send_byte(8'h03);
        chk({tag, "_no_early_tx"}, 32'(tx_cnt), 32'(t0));
        frame_end();
        chk({tag, "_tx_pulses"}, 32'(tx_cnt), 32'(t0 + 1));
        chk({tag, "_tx_data"}, 32'(tx_last), 32'(exp));
        chk({tag, "_err_cleared"}, 32'(bus.err), 32'd0);
    endtask

    initial begin
        int w0;
        bus.cs_n     = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two pixels from address 5
        w0 = we_cnt;
        push_wr(11'd5, 24'h112233);
        push_wr(11'd6, 24'h445566);
        frame_begin();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
        frame_end();
        chk("c1_writes", 32'(we_cnt - w0), 32'd2);
        chk("c1_queue_empty", 32'(exp_q.size()), 32'd0);
        read_status("c1_stat", 8'h01);

        // Wrap from the last pixel to address 0
        w0 = we_cnt;
        push_wr(11'd2047, 24'hAABBCC);
        push_wr(11'd0, 24'h010203);
        frame_begin();
        send_byte(8'h01); send_byte(8'h07); send_byte(8'hFF);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        frame_end();
        chk("c2_writes", 32'(we_cnt - w0), 32'd2);
        chk("c2_queue_empty", 32'(exp_q.size()), 32'd0);

        // Partial pixel is discarded
        w0 = we_cnt;
        frame_begin();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        frame_end();
        chk("c3_no_write", 32'(we_cnt - w0), 32'd0);

        // Byte coincident with cs_n rising is dropped
        w0 = we_cnt;
        frame_begin();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h0A);
        send_byte(8'h11); send_byte(8'h22);
        @(negedge clk);
        bus.cs_n     = 1'b1;
        bus.rx_data  = 8'h33;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("cs_override_no_write", 32'(we_cnt - w0), 32'd0);
        read_status("c3_stat", 8'h02);

        // Brightness, then a bad opcode whose trailing bytes are ignored
        frame_begin();
        send_byte(8'h02); send_byte(8'h40);
        chk("c4_brightness", 32'(bus.brightness), 32'h40);
        frame_end();
        w0 = we_cnt;
        frame_begin();
        send_byte(8'h5A);
        chk("c4_err_set", 32'(bus.err), 32'd1);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        frame_end();
        chk("c4_ignored", 32'(we_cnt - w0), 32'd0);
        chk("c4_err_sticky", 32'(bus.err), 32'd1);
        chk("c4_brightness_kept", 32'(bus.brightness), 32'h40);
        read_status("c5_stat", 8'h82);

        // Start address equal to NUM_PIXELS is out of range
        w0 = we_cnt;
        frame_begin();
        send_byte(8'h01); send_byte(8'h08); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        frame_end();
        chk("oor_no_write", 32'(we_cnt - w0), 32'd0);
        chk("oor_err", 32'(bus.err), 32'd1);
        read_status("oor_stat", 8'h82);

        // Asynchronous reset after the G byte of the second pixel
        push_wr(11'd3, 24'h112233);
        frame_begin();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h44); send_byte(8'h55);
        chk("c6_pre_addr", 32'(bus.fb_addr), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("c6_async");
        @(negedge clk);
        bus.cs_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        w0 = we_cnt;
        push_wr(11'd0, 24'hA1B2C3);
        frame_begin();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
        frame_end();
        chk("c6_writes", 32'(we_cnt - w0), 32'd1);
        read_status("c6_stat", 8'h01);

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
